module_status_recorder: RTL
===========================

// Module: module_status_recorder
// PURPOSE
//  Synthesizable front end for the dataflow status monitors. Samples one HLS block's
//  ap_start/ap_ready/ap_done/ap_continue handshake plus the global finish. Turns them
//  into timestamped event records with per-transaction latency. Buffers the records
//  in a FIFO drained over valid/ready by the downstream status-dump stage.
// PARAMETERS
//  TS_W        32  timestamp counter width
//  LAT_W       16  latency field width (saturating)
//  FIFO_DEPTH  8   record FIFO entries (power of 2, >=2)
// PORTS
//  clock        in   1                   single clock, all logic on posedge
//  reset        in   1                   synchronous, active-high
//  ap_start     in   1                   monitored block start
//  ap_ready     in   1                   monitored block ready
//  ap_done      in   1                   monitored block done
//  ap_continue  in   1                   monitored block continue (tie 1 if unused)
//  finish       in   1                   end of simulation/run
//  rec_valid    out  1                   FIFO head valid
//  rec_ready    in   1                   consumer accepts head
//  rec_flags    out  4                   {FINISH,DONE,READY,START} event bitmask
//  rec_ts       out  TS_W                timestamp of event cycle
//  rec_lat      out  LAT_W               start->done cycles (DONE records, else 0)
//  rec_stall    out  LAT_W               start-stall cycles (see CONFIGURATION)
//  busy         out  1                   FSM in RUN or HOLD
//  fifo_level   out  $clog2(FIFO_DEPTH)+1  occupied entries
//  drop_cnt     out  16                  records lost to full FIFO, saturating
//  flushed      out  1                   FINISH recorded and FIFO empty
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; ts=0; FIFO emptied; counters 0. Reset mid-run
//   discards queued records; no partial record is emitted.
//  ts: free-running, +1 per cycle after reset, wraps modulo 2^TS_W.
//  FSM IDLE/RUN/HOLD/FLUSHED, evaluated each cycle (priority top-down):
//   any state, finish=1 and not FLUSHED -> FINISH flag, ->FLUSHED; finish is taken
//    once and dominates other flags in that cycle.
//   FLUSHED: inputs ignored; leaves only via reset.
//   IDLE, ap_start=1 -> START flag, lat=0, ->RUN. START|READY if ap_ready also 1.
//   RUN, ap_start&ap_ready -> READY flag.
//   RUN/HOLD, ap_done&ap_continue -> DONE flag, rec_lat=lat. ->RUN with START and
//    lat=0 if ap_start=1, else ->IDLE.
//   RUN, ap_done&!ap_continue -> HOLD, no flag. lat keeps counting in HOLD.
//  lat: +1 per cycle in RUN/HOLD, saturates at 2^LAT_W-1.
//  Push: one record per cycle when any flag set; fields registered.
//   Record for event cycle N is visible at rec_valid in cycle N+1.
//  FIFO: show-ahead; head fields stable while rec_valid&!rec_ready.
//   Pop on rec_valid&rec_ready. Empty -> rec_valid=0, fields hold last value.
//   Full and no pop -> record dropped, drop_cnt+1 (sat 0xFFFF).
//   Full with pop same cycle -> push accepted, level unchanged.
//  flushed: registered; 1 when FSM=FLUSHED and fifo_level=0.
// CONFIGURATION
//  MSTATUS_STALL_CNT_EN defined: stall counter counts cycles with ap_start=1 &
//   ap_ready=0 (IDLE or RUN), saturating. Value is written to rec_stall on every
//   record, then cleared. Undefined: counter absent, rec_stall tied to 0.
// STRUCTURE
//  Package mstatus_pkg: state enum, FLAG_* bit indices, mstatus_rec_t struct
//   {flags,ts,lat,stall}.
//  Sub-module mstatus_fifo: parameterised sync FIFO of mstatus_rec_t with level
//   output and simultaneous push/pop when full.
// TESTING
//  1 start@ts5 (ready same cycle), done&continue@ts12 -> records {START|READY,5,0},
//    {DONE,12,lat=7}.
//  2 done@ts20, continue low 3 cycles, high @ts23 -> single DONE at ts23, lat counts
//    through HOLD.
//  3 rec_ready=0, 10 events, DEPTH=8 -> level 8, drop_cnt=2. Pop+push when full ->
//    level stays 8.
//  4 finish with ap_done same cycle -> FINISH-only record, later events ignored,
//    flushed=1 after drain.
//  5 reset asserted with 3 queued in RUN -> next cycle rec_valid=0, level=0, busy=0,
//    ts=0.
//  6 STALL_CNT_EN: ap_start high, ap_ready low 4 cycles, then high -> READY record
//    rec_stall=4. Without macro -> 0.

Source files
------------

// File: rtl/mstatus_pkg.sv
// Shared definitions for the module status recorder: FSM states, event flag
// bit positions and the default record layout.
package mstatus_pkg;

  localparam int MSTATUS_TS_W  = 32;
  localparam int MSTATUS_LAT_W = 16;

  localparam int FLAG_START  = 0;
  localparam int FLAG_READY  = 1;
  localparam int FLAG_DONE   = 2;
  localparam int FLAG_FINISH = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD,
    ST_FLUSHED
  } mstatus_state_t;

  typedef struct packed {
    logic [3:0]               flags;
    logic [MSTATUS_TS_W-1:0]  ts;
    logic [MSTATUS_LAT_W-1:0] lat;
    logic [MSTATUS_LAT_W-1:0] stall;
  } mstatus_rec_t;

endpackage

// File: rtl/mstatus_fifo.sv
// Show-ahead synchronous record FIFO with occupancy level; accepts a push
// while full when the head is popped in the same cycle.
module mstatus_fifo
  import mstatus_pkg::*;
#(
  parameter type rec_t = mstatus_rec_t,
  parameter int  DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  rec_t                     push_rec,
  input  logic                     pop,
  output logic                     valid,
  output rec_t                     head_rec,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  rec_t           mem [DEPTH];
  rec_t           last_rec;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           full;
  logic           pop_ok;
  logic           push_ok;

  assign valid   = (level != '0);
  assign full    = (level == LW'(DEPTH));
  assign pop_ok  = pop && valid;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;

  // Once drained, the outputs keep showing the last record that was popped.
  assign head_rec = valid ? mem[rd_ptr] : last_rec;

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_rec;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      last_rec <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_rec <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/module_status_recorder.sv
// Turns an HLS block's ap_* handshake plus the run finish into timestamped event
// records queued for the status-dump stage. Optional MSTATUS_STALL_CNT_EN adds a start-stall counter.
module module_status_recorder
  import mstatus_pkg::*;
#(
  parameter int TS_W       = 32,
  parameter int LAT_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          ap_start,
  input  logic                          ap_ready,
  input  logic                          ap_done,
  input  logic                          ap_continue,
  input  logic                          finish,
  output logic                          rec_valid,
  input  logic                          rec_ready,
  output logic [3:0]                    rec_flags,
  output logic [TS_W-1:0]               rec_ts,
  output logic [LAT_W-1:0]              rec_lat,
  output logic [LAT_W-1:0]              rec_stall,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_cnt,
  output logic                          flushed
);

  typedef struct packed {
    logic [3:0]       flags;
    logic [TS_W-1:0]  ts;
    logic [LAT_W-1:0] lat;
    logic [LAT_W-1:0] stall;
  } rec_t;

  localparam logic [LAT_W-1:0] LAT_MAX = '1;

  mstatus_state_t   state, state_next;
  logic [TS_W-1:0]  ts;
  logic [LAT_W-1:0] lat, lat_next, lat_inc, ev_lat;
  logic [LAT_W-1:0] stall_cnt;
  logic [3:0]       flags;
  logic             push;
  logic             fifo_drop;
  rec_t             push_rec, head_rec;

  // Latency reported on DONE includes the done cycle itself (done_ts - start_ts).
  assign lat_inc = (lat == LAT_MAX) ? lat : lat + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    flags      = '0;
    ev_lat     = '0;
    lat_next   = (state == ST_RUN || state == ST_HOLD) ? lat_inc : lat;
    if (finish && state != ST_FLUSHED) begin
      flags[FLAG_FINISH] = 1'b1;
      state_next         = ST_FLUSHED;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ap_start) begin
            flags[FLAG_START] = 1'b1;
            flags[FLAG_READY] = ap_ready;
            lat_next          = '0;
            state_next        = ST_RUN;
          end
        end
        ST_RUN, ST_HOLD: begin
          if (state == ST_RUN && ap_start && ap_ready) begin
            flags[FLAG_READY] = 1'b1;
          end
          if (ap_done && ap_continue) begin
            flags[FLAG_DONE] = 1'b1;
            ev_lat           = lat_inc;
            if (ap_start) begin
              flags[FLAG_START] = 1'b1;
              lat_next          = '0;
              state_next        = ST_RUN;
            end else begin
              state_next = ST_IDLE;
            end
          end else if (state == ST_RUN && ap_done) begin
            state_next = ST_HOLD;
          end
        end
        default: begin
          state_next = state;
        end
      endcase
    end
  end

`ifdef MSTATUS_STALL_CNT_EN
  logic stall_cyc;
  assign stall_cyc = ap_start && !ap_ready && (state == ST_IDLE || state == ST_RUN);

  // A stalled record cycle already belongs to the next record's count.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (push) begin
      stall_cnt <= LAT_W'(stall_cyc);
    end else if (stall_cyc && stall_cnt != LAT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      ts       <= '0;
      lat      <= '0;
      drop_cnt <= '0;
      flushed  <= 1'b0;
    end else begin
      ts      <= ts + 1'b1;
      lat     <= lat_next;
      flushed <= (state == ST_FLUSHED) && (fifo_level == '0);
      if (fifo_drop && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  assign push           = |flags;
  assign push_rec.flags = flags;
  assign push_rec.ts    = ts;
  assign push_rec.lat   = ev_lat;
  assign push_rec.stall = stall_cnt;

  mstatus_fifo #(
    .rec_t (rec_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_rec (push_rec),
    .pop      (rec_ready),
    .valid    (rec_valid),
    .head_rec (head_rec),
    .level    (fifo_level),
    .drop     (fifo_drop)
  );

  assign rec_flags = head_rec.flags;
  assign rec_ts    = head_rec.ts;
  assign rec_lat   = head_rec.lat;
  assign rec_stall = head_rec.stall;
  assign busy      = (state == ST_RUN) || (state == ST_HOLD);

endmodule
